// File: rtl/fnd_addsub_scan.sv
// rtl/fnd_addsub_scan.sv - add/sub with sequential BCD conversion and multiplexed FND scan
module fnd_addsub_scan #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  input  logic              i_mode,
  input  logic              i_start,
  input  logic              i_en,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_carry,
  output logic              o_neg,
  output logic              o_ovf,
  output logic [DIGITS-1:0] o_digit,
  output logic [7:0]        o_fndFont
);

  // Magnitude is one bit wider than the operands; the scratch BCD register
  // holds every decimal digit such a magnitude can need (3 bits per digit
  // is always enough), and never fewer than the displayed digits.
  localparam int MW = WIDTH + 1;
  localparam int NB = ((MW + 2) / 3 > DIGITS) ? (MW + 2) / 3 : DIGITS;
  localparam int BW = 4 * NB;
  localparam int CW = $clog2(MW);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  // A negative result gives up one digit position to the minus sign.
  localparam logic [63:0] LIM_POS = pow10(DIGITS);
  localparam logic [63:0] LIM_NEG = pow10(DIGITS - 1);

  function automatic logic [7:0] seg_font(input logic [3:0] d);
    case (d)
      4'd0:    seg_font = 8'hC0;
      4'd1:    seg_font = 8'hF9;
      4'd2:    seg_font = 8'hA4;
      4'd3:    seg_font = 8'hB0;
      4'd4:    seg_font = 8'h99;
      4'd5:    seg_font = 8'h92;
      4'd6:    seg_font = 8'h82;
      4'd7:    seg_font = 8'hF8;
      4'd8:    seg_font = 8'h80;
      4'd9:    seg_font = 8'h90;
      default: seg_font = 8'hFF;
    endcase
  endfunction

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t                state_q, state_d;
  logic [MW-1:0]         sh_q;
  logic [BW-1:0]         bcd_q;
  logic [CW-1:0]         cnt_q;
  logic [4*DIGITS-1:0]   disp_q;
  logic [PW-1:0]         pre_q;
  logic [IW-1:0]         idx_q;

  logic [MW-1:0]         sum_ab, mag;
  logic                  a_ge_b, neg_now, ovf_now;
  logic [BW-1:0]         bcd_adj, bcd_next;
  logic                  last_step;
  logic [IW:0]           msd;
  logic [3:0]            cur_digit;
  logic [7:0]            font;

  // Operand arithmetic evaluated against the live inputs, used only at the start latch
  always_comb begin
    sum_ab  = {1'b0, i_a} + {1'b0, i_b};
    a_ge_b  = (i_a >= i_b);
    neg_now = i_mode & ~a_ge_b;
    if (!i_mode)     mag = sum_ab;
    else if (a_ge_b) mag = {1'b0, i_a} - {1'b0, i_b};
    else             mag = {1'b0, i_b} - {1'b0, i_a};
    ovf_now = neg_now ? (64'(mag) >= LIM_NEG) : (64'(mag) >= LIM_POS);
  end

  // One shift-add-3 step: adjust digits >= 5, then shift in the next magnitude bit
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < NB; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    bcd_next  = (bcd_adj << 1) | BW'(sh_q[MW-1]);
    last_step = (cnt_q == CW'(WIDTH));
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state: start leaves IDLE, the final conversion step returns to it
  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) begin
      if (i_start) state_d = S_CONV;
    end else begin
      if (last_step) state_d = S_IDLE;
    end
  end

  // Operand latch, conversion datapath, flags and display register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_carry <= 1'b0;
      o_neg   <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (state_q == S_IDLE) begin
        if (i_start) begin
          sh_q    <= mag;
          bcd_q   <= '0;
          cnt_q   <= '0;
          o_busy  <= 1'b1;
          o_carry <= i_mode ? a_ge_b : sum_ab[WIDTH];
          o_neg   <= neg_now;
          o_ovf   <= ovf_now;
        end
      end else begin
        sh_q  <= sh_q << 1;
        bcd_q <= bcd_next;
        cnt_q <= cnt_q + 1'b1;
        if (last_step) begin
          disp_q <= bcd_next[4*DIGITS-1:0];
          o_busy <= 1'b0;
          o_done <= 1'b1;
        end
      end
    end
  end

  // Scan prescaler and digit index; free-running regardless of enable
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (pre_q == PW'(SCAN_DIV - 1)) begin
      pre_q <= '0;
      idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // Glyph for the currently selected digit: blanking, minus placement, overflow
  always_comb begin
    msd = '0;
    for (int k = 1; k < DIGITS; k++) begin
      if (disp_q[4*k +: 4] != 4'd0) msd = (IW+1)'(k);
    end
    cur_digit = disp_q[4*idx_q +: 4];
    if (o_ovf)                                   font = 8'hBF;
    else if ({1'b0, idx_q} <= msd)               font = seg_font(cur_digit);
    else if (o_neg && ({1'b0, idx_q} == msd + 1'b1)) font = 8'hBF;
    else                                         font = 8'hFF;
  end

  // Registered pin drivers; reset shows a rightmost '0' when enabled
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_digit   <= i_en ? ~DIGITS'(1) : '1;
      o_fndFont <= i_en ? 8'hC0 : 8'hFF;
    end else begin
      o_digit   <= i_en ? ~(DIGITS'(1) << idx_q) : '1;
      o_fndFont <= i_en ? font : 8'hFF;
    end
  end

endmodule

// File: tb/tb_fnd_addsub_scan.sv
// tb/tb_fnd_addsub_scan.sv - self-checking bench for fnd_addsub_scan (WIDTH 8 and 14)
module tb_fnd_addsub_scan;

  localparam int ND = 4;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        mode;
  logic [13:0] a_in, b_in;
  logic [1:0]  st;

  logic        busy8, done8, carry8, neg8, ovf8;
  logic [3:0]  dig8;
  logic [7:0]  font8;
  logic        busy14, done14, carry14, neg14, ovf14;
  logic [3:0]  dig14;
  logic [7:0]  font14;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  fnd_addsub_scan #(.WIDTH(8), .DIGITS(ND), .SCAN_DIV(SD)) u8 (
    .i_clk(clk), .i_reset_n(rstn), .i_a(a_in[7:0]), .i_b(b_in[7:0]),
    .i_mode(mode), .i_start(st[0]), .i_en(en),
    .o_busy(busy8), .o_done(done8), .o_carry(carry8), .o_neg(neg8), .o_ovf(ovf8),
    .o_digit(dig8), .o_fndFont(font8));

  fnd_addsub_scan #(.WIDTH(14), .DIGITS(ND), .SCAN_DIV(SD)) u14 (
    .i_clk(clk), .i_reset_n(rstn), .i_a(a_in), .i_b(b_in),
    .i_mode(mode), .i_start(st[1]), .i_en(en),
    .o_busy(busy14), .o_done(done14), .o_carry(carry14), .o_neg(neg14), .o_ovf(ovf14),
    .o_digit(dig14), .o_fndFont(font14));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [7:0] glyph(input int d);
    case (d)
      0: return 8'hC0; 1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0; 4: return 8'h99;
      5: return 8'h92; 6: return 8'h82; 7: return 8'hF8; 8: return 8'h80; default: return 8'h90;
    endcase
  endfunction

  function automatic logic [7:0] render(input int val, input int neg, input int ovf, input int idx);
    int d[ND];
    int msd;
    if (ovf != 0) return 8'hBF;
    msd = 0;
    for (int k = 0; k < ND; k++) begin
      d[k] = (val / (10 ** k)) % 10;
      if (d[k] != 0) msd = k;
    end
    if (idx <= msd) return glyph(d[idx]);
    if (neg != 0 && idx == msd + 1) return 8'hBF;
    return 8'hFF;
  endfunction

  int         m_busy[2], m_done[2], m_carry[2], m_neg[2], m_ovf[2];
  int         m_disp[2], m_res[2], m_left[2], m_pre[2], m_idx[2];
  logic [3:0] m_dig[2];
  logic [7:0] m_font[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int w, av, bv;
      w  = (k == 0) ? 8 : 14;
      av = int'(a_in) % (1 << w);
      bv = int'(b_in) % (1 << w);
      if (!rstn) begin
        m_busy[k] = 0; m_done[k] = 0; m_carry[k] = 0; m_neg[k] = 0; m_ovf[k] = 0;
        m_disp[k] = 0; m_left[k] = 0; m_pre[k] = 0; m_idx[k] = 0;
        m_dig[k]  = en ? 4'b1110 : 4'b1111;
        m_font[k] = en ? 8'hC0 : 8'hFF;
      end else begin
        m_dig[k]  = en ? ~(4'b0001 << m_idx[k]) : 4'b1111;
        m_font[k] = en ? render(m_disp[k], m_neg[k], m_ovf[k], m_idx[k]) : 8'hFF;
        if (m_pre[k] == SD - 1) begin
          m_pre[k] = 0;
          m_idx[k] = (m_idx[k] + 1) % ND;
        end else begin
          m_pre[k]++;
        end
        m_done[k] = 0;
        if (m_busy[k] != 0) begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            m_busy[k] = 0;
            m_done[k] = 1;
            m_disp[k] = m_res[k] % (10 ** ND);
          end
        end else if (st[k]) begin
          if (mode) begin
            m_res[k]   = (av >= bv) ? av - bv : bv - av;
            m_carry[k] = (av >= bv) ? 1 : 0;
            m_neg[k]   = (av < bv) ? 1 : 0;
          end else begin
            m_res[k]   = av + bv;
            m_carry[k] = (m_res[k] >= (1 << w)) ? 1 : 0;
            m_neg[k]   = 0;
          end
          m_ovf[k]  = (m_neg[k] != 0) ? ((m_res[k] >= 10 ** (ND - 1)) ? 1 : 0)
                                      : ((m_res[k] >= 10 ** ND) ? 1 : 0);
          m_busy[k] = 1;
          m_left[k] = w + 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy8",   busy8,   m_busy[0]);
      chk("done8",   done8,   m_done[0]);
      chk("carry8",  carry8,  m_carry[0]);
      chk("neg8",    neg8,    m_neg[0]);
      chk("ovf8",    ovf8,    m_ovf[0]);
      chk("digit8",  dig8,    m_dig[0]);
      chk("font8",   font8,   m_font[0]);
      chk("busy14",  busy14,  m_busy[1]);
      chk("done14",  done14,  m_done[1]);
      chk("carry14", carry14, m_carry[1]);
      chk("neg14",   neg14,   m_neg[1]);
      chk("ovf14",   ovf14,   m_ovf[1]);
      chk("digit14", dig14,   m_dig[1]);
      chk("font14",  font14,  m_font[1]);
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  function automatic logic busy_of(input int k);
    return (k == 0) ? busy8 : busy14;
  endfunction
  function automatic logic done_of(input int k);
    return (k == 0) ? done8 : done14;
  endfunction

  task automatic run_op(input int k, input int a, input int b, input logic md, output int busy_n);
    @(negedge clk);
    a_in = 14'(a); b_in = 14'(b); mode = md; st[k] = 1'b1;
    @(negedge clk);
    st[k] = 1'b0;
    busy_n = 0;
    while (busy_of(k) && busy_n < 60) begin
      busy_n++;
      @(negedge clk);
    end
    chk("done_pulse", done_of(k), 1'b1);
    @(negedge clk);
    chk("done_single", done_of(k), 1'b0);
  endtask

  task automatic scan_chk(input int k, input int d, input logic [7:0] exp);
    int n;
    logic [3:0] want;
    n = 0;
    want = ~(4'b0001 << d);
    while (((k == 0) ? dig8 : dig14) !== want && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("scan_u%0d_d%0d_sel", k, d), (k == 0) ? dig8 : dig14, want);
    chk($sformatf("scan_u%0d_d%0d_font", k, d), (k == 0) ? font8 : font14, exp);
  endtask

  task automatic scan4(input int k, input logic [7:0] f0, input logic [7:0] f1,
                       input logic [7:0] f2, input logic [7:0] f3);
    scan_chk(k, 0, f0);
    scan_chk(k, 1, f1);
    scan_chk(k, 2, f2);
    scan_chk(k, 3, f3);
  endtask

  initial begin
    int bn, n, dn;
    rstn = 1'b0; en = 1'b1; mode = 1'b0; a_in = '0; b_in = '0; st = 2'b00;

    // reset held three cycles
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_digit", dig8, 4'b1110);
    chk("rst_font", font8, 8'hC0);
    rstn = 1'b1;
    scan4(0, 8'hC0, 8'hFF, 8'hFF, 8'hFF);

    // 255 + 255 = 510
    run_op(0, 255, 255, 1'b0, bn);
    chk("add_busy_cycles", 32'(bn), 32'd9);
    chk("add_carry", carry8, 1'b1);
    chk("add_neg", neg8, 1'b0);
    scan4(0, 8'hC0, 8'hF9, 8'h92, 8'hFF);

    // 3 - 10 = -7, then 10 - 3 = 7
    run_op(0, 3, 10, 1'b1, bn);
    chk("sub_neg", neg8, 1'b1);
    chk("sub_carry", carry8, 1'b0);
    scan4(0, 8'hF8, 8'hBF, 8'hFF, 8'hFF);
    run_op(0, 10, 3, 1'b1, bn);
    chk("sub2_neg", neg8, 1'b0);
    chk("sub2_carry", carry8, 1'b1);
    scan4(0, 8'hF8, 8'hFF, 8'hFF, 8'hFF);

    // overflow boundaries on the 14-bit instance
    run_op(1, 9999, 1, 1'b0, bn);
    chk("ovf_add", ovf14, 1'b1);
    scan4(1, 8'hBF, 8'hBF, 8'hBF, 8'hBF);
    run_op(1, 0, 1000, 1'b1, bn);
    chk("ovf_neg1000", ovf14, 1'b1);
    scan4(1, 8'hBF, 8'hBF, 8'hBF, 8'hBF);
    run_op(1, 0, 999, 1'b1, bn);
    chk("ovf_neg999", ovf14, 1'b0);
    scan4(1, 8'h90, 8'h90, 8'h90, 8'hBF);
    run_op(1, 9999, 0, 1'b0, bn);
    chk("ovf_9999", ovf14, 1'b0);
    scan4(1, 8'h90, 8'h90, 8'h90, 8'h90);

    // second start during conversion is ignored: 100 + 23 stays
    @(negedge clk);
    a_in = 14'd100; b_in = 14'd23; mode = 1'b0; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (2) @(negedge clk);
    a_in = 14'd1; b_in = 14'd1; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("busy_ign_done", done8, 1'b1);
    repeat (12) @(negedge clk);
    chk("busy_ign_idle", busy8, 1'b0);
    scan4(0, 8'hB0, 8'hA4, 8'hF9, 8'hFF);

    // reset during conversion
    @(negedge clk);
    a_in = 14'd50; b_in = 14'd50; mode = 1'b0; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("midrst_busy", busy8, 1'b0);
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done8) dn++;
    end
    chk("midrst_no_done", 32'(dn), 32'd0);
    scan4(0, 8'hC0, 8'hFF, 8'hFF, 8'hFF);

    // display enable off for 20 cycles, scan keeps running underneath
    @(negedge clk);
    en = 1'b0;
    repeat (20) @(negedge clk);
    chk("en_off_digit", dig8, 4'b1111);
    chk("en_off_font", font8, 8'hFF);
    en = 1'b1;
    repeat (12) @(negedge clk);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
